// File: rtl/mem_pkg.sv
// Shared constants and types for the word-memory responder.
package mem_pkg;

  localparam int ADDR_W = 8;                 // byte-address width
  localparam int DATA_W = 16;                // word width
  localparam int DEPTH  = 128;               // words of storage, 2**(ADDR_W-1)
  localparam int IDX_W  = ADDR_W - 1;        // word-index width
  localparam int CNT_W  = 4;                 // wait counter covers 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Word index of a byte address (bit 0 selects the byte and is dropped).
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, combinational read port.
// No reset on the contents; words are undefined until written or preloaded.
module mem_array
  import mem_pkg::*;
#(
  parameter int IW = IDX_W,
  parameter int DW = DATA_W,
  parameter int DP = DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] memory [DP];

  // Commit a write on the clock edge selected by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      memory[idx] <= wdata;
    end
  end

  assign rdata = memory[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one byte-addressed request, holds it for
// WAIT_CYCLES wait states, performs the word access, then presents the
// response until the requester takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  mem_req_t          req_reg;
  mem_req_t          acc;
  logic              accept;
  logic              exec;
  logic              misaligned;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && (state_reg == IDLE);

  // Pick the access source: with zero wait states the access runs on the
  // accept edge straight from the inputs, otherwise from the latched request.
  always_comb begin
    acc = req_reg;
    if (state_reg == IDLE) begin
      acc.we    = req_we;
      acc.addr  = req_addr;
      acc.wdata = req_wdata;
    end
  end

  assign exec       = (accept && (WAIT_INIT == '0)) ||
                      ((state_reg == WAIT) && (cnt_reg == CNT_ONE));
  assign misaligned = acc.addr[0];
  assign mem_we     = exec && acc.we && !misaligned;

  mem_array u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (word_index(acc.addr)),
    .wdata (acc.wdata),
    .rdata (mem_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_INIT == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request on the accept edge; later changes on req_* are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg <= '0;
    end else if (accept) begin
      req_reg <= acc;
    end
  end

  // Response registers: load when the access executes, clear on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else if (exec) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= misaligned;
      rsp_rdata_reg <= (acc.we || misaligned) ? '0 : mem_rdata;
    end else if ((state_reg == RESP) && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule
